key_schedule: RTL

KEY_SCHEDULE -- requirements
Module: key_schedule

---
 rtl/key_schedule.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/key_schedule.sv
// AES-128 key expansion: emits round keys 0..NUM_ROUNDS one per cycle over a valid/ready handshake.
// Define KEY_SCHEDULE_REVERSE_EN to add a key buffer and honour dec (descending output order).
module key_schedule #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         dec,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);
`ifdef KEY_SCHEDULE_REVERSE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, EMIT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd2} state_t;
`endif

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    // Standard AES S-box; entry 0 occupies the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sub_byte(w3[23:16]) ^ rc, sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;
    logic [127:0] key_nxt;

    assign key_nxt = next_key(key_q, rcon(idx_q + 4'd1));

`ifdef KEY_SCHEDULE_REVERSE_EN
    logic         dec_q, dec_d;
    logic [127:0] kbuf_q [NUM_ROUNDS+1];
`endif

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef KEY_SCHEDULE_REVERSE_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = 4'd0;
                    state_d = EMIT;
`ifdef KEY_SCHEDULE_REVERSE_EN
                    dec_d   = dec;
                    if (dec) state_d = GEN;
`endif
                end
            end
`ifdef KEY_SCHEDULE_REVERSE_EN
            // Each GEN cycle stores key_q at idx_q; after the last store EMIT starts from the top.
            GEN: begin
                if (idx_q < LAST) begin
                    key_d = key_nxt;
                    idx_d = idx_q + 4'd1;
                end else begin
                    state_d = EMIT;
                end
            end
`endif
            EMIT: begin
                if (rk_ready) begin
`ifdef KEY_SCHEDULE_REVERSE_EN
                    if (dec_q) begin
                        if (idx_q == 4'd0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q - 4'd1;
                        end
                    end else
`endif
                    if (idx_q < LAST) begin
                        key_d = key_nxt;
                        idx_d = idx_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef KEY_SCHEDULE_REVERSE_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef KEY_SCHEDULE_REVERSE_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rk_idx   = rk_valid ? idx_q : 4'd0;

`ifdef KEY_SCHEDULE_REVERSE_EN
    always_ff @(posedge clk) begin
        if (state_q == GEN) kbuf_q[idx_q] <= key_q;
    end
    assign rk_out = !rk_valid ? '0 : (dec_q ? kbuf_q[idx_q] : key_q);
`else
    logic unused_dec;
    assign unused_dec = dec;
    assign rk_out = rk_valid ? key_q : '0;
`endif

endmodule
